// File: rtl/even_odd_tx.sv
// Serial frame transmitter: start bit, DATA_W payload bits LSB first, even/odd
// parity bit, stop bit. Back-to-back frames are accepted during the stop bit.
module even_odd_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              par_mode,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              par_bit, par_bit_next;
  logic              out_next;

  // out is registered alongside the state so it reflects the state entered
  // on the same edge (start seen at edge N gives out=0 right after edge N).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      out     <= 1'b1;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      cnt     <= cnt_next;
      par_bit <= par_bit_next;
      out     <= out_next;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    cnt_next     = cnt;
    par_bit_next = par_bit;
    out_next     = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = START;
          shreg_next   = data;
          par_bit_next = (^data) ^ par_mode;
          out_next     = 1'b0;
        end
      end
      START: begin
        state_next = DATA;
        cnt_next   = '0;
        out_next   = shreg[0];
        shreg_next = shreg >> 1;
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          state_next = PARITY;
          out_next   = par_bit;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          out_next   = shreg[0];
          shreg_next = shreg >> 1;
        end
      end
      PARITY: begin
        state_next = STOP;
        out_next   = 1'b1;
      end
      STOP: begin
        if (start) begin
          state_next   = START;
          shreg_next   = data;
          par_bit_next = (^data) ^ par_mode;
          out_next     = 1'b0;
        end else begin
          state_next = IDLE;
          out_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        out_next   = 1'b1;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == STOP);

endmodule

// File: doc/even_odd_tx.md
EVEN_ODD_TX -- requirements
Module: even_odd_tx

Interface
REQ-001 Parameter DATA_W, default 8, is the payload width in bits per frame; legal range 2..16.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  frame request, sampled on the rising edge of clk.
REQ-005 data  input  DATA_W  parallel payload, captured on start acceptance.
REQ-006 par_mode  input  1  parity select, captured on start acceptance: 0 = even parity, 1 = odd parity.
REQ-007 out  output  1  serial line; idle level 1.
REQ-008 busy  output  1  high while a frame is being transmitted.
REQ-009 done  output  1  single-cycle pulse marking the stop bit of a frame.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP, all registered.
REQ-011 Transitions:
- IDLE->START when start=1.
- START->DATA unconditionally.
- DATA->PARITY after DATA_W bits.
- PARITY->STOP unconditionally.
- STOP->START when start=1, else STOP->IDLE.
REQ-012 out SHALL be a registered function of state: IDLE=1, START=0, DATA=current payload bit, PARITY=parity bit, STOP=1.
REQ-013 The payload SHALL be sent LSB first, one bit per clock, from an internal shift register loaded with data on acceptance.
REQ-014 A bit counter of ceil(log2(DATA_W))+1 bits SHALL count DATA cycles from 0 to DATA_W-1, with no wrap beyond DATA_W-1.
REQ-015 The parity bit SHALL be chosen as follows:
- par_mode=0: the count of ones in payload plus parity bit is even.
- par_mode=1: the count of ones in payload plus parity bit is odd.
REQ-016 Parity SHALL be computed from the captured payload and mode, so changes on data or par_mode after acceptance have no effect on the frame.
REQ-017 Latency: start sampled high at edge N in IDLE SHALL drive out=0 and busy=1 from edge N.
REQ-018 A frame SHALL occupy exactly DATA_W+3 consecutive cycles.
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 done SHALL be 1 only during the STOP cycle.
REQ-021 start asserted in START, DATA or PARITY SHALL be ignored, with no queuing and no frame corruption.
REQ-022 start asserted during STOP SHALL be accepted as a back-to-back request:
- the next START follows immediately, with no idle cycle;
- busy stays 1.
REQ-023 start held continuously high SHALL produce contiguous frames, each using the data and par_mode values present during that frame's acceptance cycle.

Reset
REQ-024 While rst=1, and immediately on its assertion regardless of clk, the outputs SHALL be out=1, busy=0, done=0, and the state SHALL be IDLE.
REQ-025 While rst=1, the shift register and bit counter SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no partial completion and no done pulse.
REQ-027 After rst deasserts, the first accepted start SHALL begin a fresh frame.
REQ-028 start sampled on the same edge where rst is still 1 SHALL be ignored.

Verification
REQ-029 DATA_W=8, data=8'hA5, par_mode=0, one-cycle start -> out = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; done high only on the final 1; busy high for 11 cycles.
REQ-030 data=8'hA5, par_mode=1 -> identical frame except the parity bit is 1; data=8'h07, par_mode=0 -> parity bit 1; data=8'h00, par_mode=1 -> parity bit 1.
REQ-031 Back-to-back: frame 8'h3C even, then start=1 in its STOP cycle with 8'hFF odd -> the second start bit immediately follows the stop bit, the second parity bit is 1, busy never drops, and done pulses twice, 11 cycles apart.
REQ-032 Ignored start: pulse start with data=8'h00 in the 4th DATA cycle of an 8'hA5 frame -> the frame is unchanged and no extra frame follows.
REQ-033 Reset mid-frame: assert rst for 3 cycles during the PARITY cycle -> out=1, busy=0, done=0 immediately and without a clock edge; a new start after release sends a complete, correct frame.
REQ-034 Data change after acceptance: change data and par_mode every cycle during a frame -> the serialized bits and parity match the accepted values only.
